// File: rtl/mix_col_engine_if.sv
// Stream bundle for the AES column mixer: an input beat channel, an output
// result channel and the transfer counter, each with valid/ready flow control.
interface mix_col_engine_if #(
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_inv;
    logic [32*LANES-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_inv;
    logic [32*LANES-1:0]  out_data;
    logic [15:0]          beat_cnt;

    // Producer of beats and consumer of results
    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_inv, out_data, beat_cnt
    );

    // The mixer itself
    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_inv, out_data, beat_cnt
    );
endinterface

// File: rtl/mix_col_engine.sv
// Pipelined GF(2^8) column mixer for AES (MixColumns / InvMixColumns chosen
// per beat). All constant multiplies are built from xtime over 0x11B, so no
// lookup tables are used. PIPE=1 has only the output register; PIPE=2 adds a
// stage holding each byte together with its x2/x4/x8 multiples. The whole
// pipeline advances together whenever the output register is empty or being
// drained.
module mix_col_engine #(
    parameter int LANES = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mix_col_engine_if.slave  bus
);
    localparam int W = 32 * LANES;

    generate
        if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
            $error("mix_col_engine: PIPE must be 1 or 2");
        end
    endgenerate

    // Multiply a byte by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Mix one column given the byte multiples a, 2a, 4a, 8a for each row.
    // Row r takes coefficient set (c0,c1,c2,c3) applied to rows r, r+1, r+2, r+3.
    function automatic logic [31:0] mix_word(
        input logic [31:0] a,
        input logic [31:0] x2,
        input logic [31:0] x4,
        input logic [31:0] x8,
        input logic        inv
    );
        logic [31:0] m3, m9, m11, m13, m14, res;
        m3  = x2 ^ a;
        m9  = x8 ^ a;
        m11 = x8 ^ x2 ^ a;
        m13 = x8 ^ x4 ^ a;
        m14 = x8 ^ x4 ^ x2;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[8*r +: 8] = m14[8*r +: 8]
                              ^ m11[8*((r+1)%4) +: 8]
                              ^ m13[8*((r+2)%4) +: 8]
                              ^ m9[8*((r+3)%4) +: 8];
            end else begin
                res[8*r +: 8] = x2[8*r +: 8]
                              ^ m3[8*((r+1)%4) +: 8]
                              ^ a[8*((r+2)%4) +: 8]
                              ^ a[8*((r+3)%4) +: 8];
            end
        end
        return res;
    endfunction

    logic          advance;
    logic          out_valid_q;
    logic          out_inv_q;
    logic [W-1:0]  out_data_q;
    logic [15:0]   beat_cnt_q;

    logic [W-1:0]  in_x2;
    logic [W-1:0]  in_x4;
    logic [W-1:0]  in_x8;

    logic [W-1:0]  src_a;
    logic [W-1:0]  src_x2;
    logic [W-1:0]  src_x4;
    logic [W-1:0]  src_x8;
    logic          src_inv;
    logic          src_valid;
    logic [W-1:0]  mixed;

    // The pipeline moves whenever the output slot is free or being taken
    always_comb begin
        advance = !out_valid_q || bus.out_ready;
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inv   = out_inv_q;
    assign bus.out_data  = out_data_q;
    assign bus.beat_cnt  = beat_cnt_q;

    // Doubling chain 2a, 4a, 8a for every incoming byte
    always_comb begin
        in_x2 = '0;
        in_x4 = '0;
        in_x8 = '0;
        for (int i = 0; i < 4*LANES; i++) begin
            in_x2[8*i +: 8] = xtime(bus.in_data[8*i +: 8]);
            in_x4[8*i +: 8] = xtime(in_x2[8*i +: 8]);
            in_x8[8*i +: 8] = xtime(in_x4[8*i +: 8]);
        end
    end

    generate
        if (PIPE == 2) begin : g_pipe2
            logic [W-1:0] s1_a;
            logic [W-1:0] s1_x2;
            logic [W-1:0] s1_x4;
            logic [W-1:0] s1_x8;
            logic         s1_inv;
            logic         s1_valid;

            // First stage captures the bytes and their multiples with the mode
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_inv   <= 1'b0;
                    s1_a     <= '0;
                    s1_x2    <= '0;
                    s1_x4    <= '0;
                    s1_x8    <= '0;
                end else if (advance) begin
                    s1_valid <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1_inv <= bus.in_inv;
                        s1_a   <= bus.in_data;
                        s1_x2  <= in_x2;
                        s1_x4  <= in_x4;
                        s1_x8  <= in_x8;
                    end
                end
            end

            assign src_a     = s1_a;
            assign src_x2    = s1_x2;
            assign src_x4    = s1_x4;
            assign src_x8    = s1_x8;
            assign src_inv   = s1_inv;
            assign src_valid = s1_valid;
        end else begin : g_pipe1
            assign src_a     = bus.in_data;
            assign src_x2    = in_x2;
            assign src_x4    = in_x4;
            assign src_x8    = in_x8;
            assign src_inv   = bus.in_inv;
            assign src_valid = bus.in_valid;
        end
    endgenerate

    // XOR sums for every lane in parallel; lanes never interact
    always_comb begin
        mixed = '0;
        for (int l = 0; l < LANES; l++) begin
            mixed[32*l +: 32] = mix_word(src_a[32*l +: 32], src_x2[32*l +: 32],
                                         src_x4[32*l +: 32], src_x8[32*l +: 32],
                                         src_inv);
        end
    end

    // Output register: loads with the pipeline, holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inv_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (advance) begin
            out_valid_q <= src_valid;
            if (src_valid) begin
                out_inv_q  <= src_inv;
                out_data_q <= mixed;
            end
        end
    end

    // Count completed output transfers, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_mix_col_engine.sv
// Directed bench for mix_col_engine (LANES=4, PIPE=2) using FIPS-197 columns
// and hand-computed inverse products.
module tb_mix_col_engine;
    localparam int LANES = 4;
    localparam int W     = 32 * LANES;

    localparam logic [W-1:0] ST_IN   = {32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2, 32'h455313DB};
    localparam logic [W-1:0] ST_FWD  = {32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E};
    localparam logic [W-1:0] INV_IN  = {32'h00000001, 32'h00000080, 32'h9D58DC9F, 32'hBCA14D8E};
    localparam logic [W-1:0] INV_OUT = {32'h0B0D090E, 32'hF7DAEC41, 32'h5C220AF2, 32'h455313DB};
    localparam logic [W-1:0] V2_IN   = {32'hC6C6C6C6, 32'h01010101, 32'h455313DB, 32'h5C220AF2};
    localparam logic [W-1:0] V2_OUT  = {32'hC6C6C6C6, 32'h01010101, 32'hBCA14D8E, 32'h9D58DC9F};
    localparam logic [W-1:0] V3_IN   = {32'hBCA14D8E, 32'h00000001, 32'h00000080, 32'h9D58DC9F};
    localparam logic [W-1:0] V3_OUT  = {32'h455313DB, 32'h0B0D090E, 32'hF7DAEC41, 32'h5C220AF2};

    logic clk = 1'b0;
    logic rst_n;

    mix_col_engine_if #(.LANES(LANES)) bus();

    mix_col_engine #(.LANES(LANES), .PIPE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int total_xfers  = 0;

    logic [W-1:0] vin  [4];
    logic [W-1:0] vexp [4];
    logic         vinv [4];

    // Present one beat on an empty pipeline and collect its result
    task automatic run_beat(input logic [W-1:0] d, input logic inv,
                            output logic [W-1:0] got, output logic got_inv,
                            output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_inv    = inv;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got     = bus.out_data;
        got_inv = bus.out_inv;
        if (bus.out_valid) begin
            @(posedge clk);
            total_xfers++;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inv    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_inv !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_inv: got %b expected 0", bus.out_inv);
        end
        tests_run++;
        if (bus.out_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        tests_run++;
        if (bus.beat_cnt !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_beat_cnt: got %h expected 0000", bus.beat_cnt);
        end
        rst_n       = 1'b1;
        total_xfers = 0;
    endtask

    task automatic test_fips_vectors();
        logic [W-1:0] got;
        logic         got_inv;
        int           lat;
        run_beat(ST_IN, 1'b0, got, got_inv, lat);
        tests_run++;
        if (got !== ST_FWD) begin
            tests_failed++;
            $display("[TB] FAIL fips_fwd_data: got %h expected %h", got, ST_FWD);
        end
        tests_run++;
        if (got_inv !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fips_fwd_inv: got %b expected 0", got_inv);
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL fips_fwd_latency: got %0d expected 2", lat);
        end
        run_beat(ST_FWD, 1'b1, got, got_inv, lat);
        tests_run++;
        if (got !== ST_IN) begin
            tests_failed++;
            $display("[TB] FAIL fips_inv_data: got %h expected %h", got, ST_IN);
        end
        tests_run++;
        if (got_inv !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fips_inv_inv: got %b expected 1", got_inv);
        end
    endtask

    task automatic test_inverse();
        logic [W-1:0] got;
        logic         got_inv;
        int           lat;
        run_beat(INV_IN, 1'b1, got, got_inv, lat);
        tests_run++;
        if (got !== INV_OUT) begin
            tests_failed++;
            $display("[TB] FAIL inverse_single_bit: got %h expected %h", got, INV_OUT);
        end
        @(negedge clk);
        tests_run++;
        if (bus.beat_cnt !== 16'(total_xfers)) begin
            tests_failed++;
            $display("[TB] FAIL inverse_beat_cnt: got %0d expected %0d", bus.beat_cnt, total_xfers);
        end
    endtask

    task automatic test_back_to_back();
        int           n = 24;
        int           sent = 0;
        int           rcvd = 0;
        int           cycles = 0;
        logic         held_valid = 1'b0;
        logic         held_inv = 1'b0;
        logic [W-1:0] held_data = '0;
        while (rcvd < n && cycles < 600) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vin[sent % 4];
                bus.in_inv   = vinv[sent % 4];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (held_valid) begin
                tests_run++;
                if ({bus.out_valid, bus.out_inv, bus.out_data} !== {1'b1, held_inv, held_data}) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold: got %b/%b/%h expected 1/%b/%h",
                             bus.out_valid, bus.out_inv, bus.out_data, held_inv, held_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if ({bus.out_inv, bus.out_data} !== {vinv[rcvd % 4], vexp[rcvd % 4]}) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_beat_%0d: got %b/%h expected %b/%h", rcvd,
                             bus.out_inv, bus.out_data, vinv[rcvd % 4], vexp[rcvd % 4]);
                end
                rcvd++;
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_inv   = bus.out_inv;
            held_data  = bus.out_data;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            cycles++;
        end
        total_xfers += rcvd;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (rcvd !== n) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d expected %0d", rcvd, n);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stream_no_duplicate: got out_valid %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.beat_cnt !== 16'(total_xfers)) begin
            tests_failed++;
            $display("[TB] FAIL stream_beat_cnt: got %0d expected %0d", bus.beat_cnt, total_xfers);
        end
    endtask

    task automatic test_reset_in_flight();
        logic [W-1:0] got;
        logic         got_inv;
        int           lat;
        logic         stale;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = ST_IN;
        bus.in_inv    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = INV_IN;
        bus.in_inv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flight_out_valid: got %b expected 1", bus.out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.out_valid, bus.beat_cnt, bus.out_data} !== {1'b0, 16'h0000, {W{1'b0}}}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got valid %b cnt %h data %h expected 0/0000/0",
                     bus.out_valid, bus.beat_cnt, bus.out_data);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        total_xfers   = 0;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        tests_run++;
        if (stale !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_stale: got %b expected 0", stale);
        end
        run_beat(V2_IN, 1'b0, got, got_inv, lat);
        tests_run++;
        if ({got_inv, got} !== {1'b0, V2_OUT}) begin
            tests_failed++;
            $display("[TB] FAIL fresh_beat: got %b/%h expected 0/%h", got_inv, got, V2_OUT);
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL fresh_latency: got %0d expected 2", lat);
        end
        @(negedge clk);
        tests_run++;
        if (bus.beat_cnt !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL fresh_beat_cnt: got %h expected 0001", bus.beat_cnt);
        end
    endtask

    task automatic test_beat_cnt_wrap();
        int target = 65537;
        int sent = 0;
        int rcvd = 0;
        int cycles = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        while (rcvd < target && cycles < 70000) begin
            @(negedge clk);
            bus.in_valid = (sent < target);
            bus.in_data  = vin[sent % 4];
            bus.in_inv   = vinv[sent % 4];
            #1;
            if (rcvd == 65535) begin
                tests_run++;
                if (bus.beat_cnt !== 16'hFFFF) begin
                    tests_failed++;
                    $display("[TB] FAIL cnt_at_ffff: got %h expected ffff", bus.beat_cnt);
                end
            end
            if (rcvd == 65536) begin
                tests_run++;
                if (bus.beat_cnt !== 16'h0000) begin
                    tests_failed++;
                    $display("[TB] FAIL cnt_wrap_zero: got %h expected 0000", bus.beat_cnt);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) rcvd++;
            @(posedge clk);
            cycles++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (rcvd !== target) begin
            tests_failed++;
            $display("[TB] FAIL wrap_transfers: got %0d expected %0d", rcvd, target);
        end
        tests_run++;
        if (bus.beat_cnt !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL wrap_beat_cnt: got %h expected 0001", bus.beat_cnt);
        end
    endtask

    initial begin
        vin[0] = ST_IN;   vinv[0] = 1'b0; vexp[0] = ST_FWD;
        vin[1] = INV_IN;  vinv[1] = 1'b1; vexp[1] = INV_OUT;
        vin[2] = V2_IN;   vinv[2] = 1'b0; vexp[2] = V2_OUT;
        vin[3] = V3_IN;   vinv[3] = 1'b1; vexp[3] = V3_OUT;
        test_reset();
        test_fips_vectors();
        test_inverse();
        test_back_to_back();
        test_reset_in_flight();
        test_beat_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
